// File: rtl/mem_rmw_ctrl.sv
// Read-modify-write sequencer between the LSU and a word-only data RAM.
// Sub-word stores read the word, merge the new bytes, and write the word back.
module mem_rmw_ctrl #(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             sw,
    input  logic             sh,
    input  logic             sb,
    input  logic             ld,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] din,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_re,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_SW, OP_SH, OP_SB, OP_LD} op_t;

    localparam logic [2:0] CNT_LAST = 3'(RD_LAT - 1);

    state_t           state_reg;
    op_t              op_reg;
    op_t              op_next;
    logic [2:0]       cnt_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] din_reg;
    logic [WIDTH-1:0] rd_reg;
    logic [WIDTH-1:0] rdata_reg;

    // Several flags may be set at once; the widest store wins.
    always_comb begin
        op_next = OP_NONE;
        if (sw)      op_next = OP_SW;
        else if (sh) op_next = OP_SH;
        else if (sb) op_next = OP_SB;
        else if (ld) op_next = OP_LD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= OP_NONE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
            rd_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg <= addr;
                        din_reg  <= din;
                        op_reg   <= op_next;
                        case (op_next)
                            OP_SW:   state_reg <= WRITE;
                            OP_NONE: state_reg <= DONE;
                            default: state_reg <= READ;
                        endcase
                    end
                end
                READ: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == CNT_LAST) begin
                        rd_reg <= mem_rdata;
                        if (op_reg == OP_LD) begin
                            rdata_reg <= mem_rdata;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE:   state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign mem_re     = (state_reg == READ);
    assign mem_we     = (state_reg == WRITE);
    assign resp_valid = (state_reg == DONE);
    assign resp_rdata = rdata_reg;
    assign mem_addr   = {addr_reg[WIDTH-1:2], 2'b00};

    // Per-lane merge from latched registers only, so the word is stable during WRITE.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic sh_hit;
        logic sb_hit;
        assign sh_hit = (op_reg == OP_SH) && (addr_reg[1] == 1'(gi / 2));
        assign sb_hit = (op_reg == OP_SB) && (addr_reg[1:0] == 2'(gi));
        assign mem_wdata[8*gi +: 8] = (op_reg == OP_SW) ? din_reg[8*gi +: 8]     :
                                      sh_hit            ? din_reg[8*(gi%2) +: 8] :
                                      sb_hit            ? din_reg[7:0]           :
                                                          rd_reg[8*gi +: 8];
    end
endmodule
